// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer among NumReq byte requesters,
// one byte per grant, with a watchdog for a transmitter that never raises busy.
module uart_tx_arbiter #(
  parameter int unsigned NumReq       = 2,
  parameter int unsigned StartTimeout = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NumReq-1:0]         req_i,
  input  logic [8*NumReq-1:0]       req_data_i,
  output logic [NumReq-1:0]         ack_o,
  output logic                      tx_start_o,
  output logic [7:0]                tx_data_o,
  input  logic                      tx_busy_i,
  output logic [$clog2(NumReq)-1:0] grant_id_o,
  output logic                      active_o,
  output logic                      timeout_err_o,
  output logic [15:0]               byte_count_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned WdW  = (StartTimeout > 2) ? $clog2(StartTimeout) : 1;
  // Watchdog value on the cycle whose increment would reach StartTimeout-1.
  localparam logic [WdW-1:0] WdLast = WdW'(StartTimeout - 2);

  typedef enum logic [1:0] {StIdle, StStart, StWaitAccept, StWaitDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [IdxW-1:0] cand, winner;
  logic [7:0]      data_q, data_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic            err_q, err_d;
  logic [15:0]     count_q, count_d;
  logic [7:0]      req_bytes [NumReq];

  always_comb begin
    for (int i = 0; i < int'(NumReq); i++) begin
      req_bytes[i] = req_data_i[8*i +: 8];
    end
  end

  // Scan from furthest to nearest so the first set bit after last_q wins.
  always_comb begin
    winner = last_q;
    cand   = '0;
    for (int k = int'(NumReq); k >= 1; k--) begin
      cand = IdxW'((int'(last_q) + k) % int'(NumReq));
      if (req_i[cand]) begin
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    data_d  = data_q;
    wd_d    = wd_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (|req_i && !tx_busy_i) begin
          grant_d = winner;
          data_d  = req_bytes[winner];
          state_d = StStart;
        end
      end
      StStart: begin
        last_d  = grant_q;
        wd_d    = '0;
        state_d = StWaitAccept;
      end
      StWaitAccept: begin
        if (tx_busy_i) begin
          state_d = StWaitDone;
        end else if (wd_q == WdLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!tx_busy_i) begin
          count_d = count_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NumReq - 1);
      data_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    ack_o = '0;
    if (state_q == StStart) begin
      ack_o[grant_q] = 1'b1;
    end
  end

  assign tx_start_o    = (state_q == StStart);
  assign tx_data_o     = data_q;
  assign grant_id_o    = grant_q;
  assign active_o      = (state_q != StIdle);
  assign timeout_err_o = err_q;
  assign byte_count_o  = count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a transaction-level model predicts each grant,
// its data and the completion/timeout outcome of every frame.
module tb_uart_tx_arbiter;

  localparam int unsigned NumReq       = 2;
  localparam int unsigned StartTimeout = 4;
  localparam int unsigned IdxW         = $clog2(NumReq);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NumReq-1:0]     req;
  logic [8*NumReq-1:0]   req_data;
  logic                  tx_busy;
  logic [NumReq-1:0]     ack;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic [IdxW-1:0]       grant_id;
  logic                  active;
  logic                  timeout_err;
  logic [15:0]           byte_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state: last served requester, completed bytes, sticky error.
  int unsigned m_last;
  logic [15:0] m_count;
  logic        m_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NumReq       (NumReq),
    .StartTimeout (StartTimeout)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_i         (req),
    .req_data_i    (req_data),
    .ack_o         (ack),
    .tx_start_o    (tx_start),
    .tx_data_o     (tx_data),
    .tx_busy_i     (tx_busy),
    .grant_id_o    (grant_id),
    .active_o      (active),
    .timeout_err_o (timeout_err),
    .byte_count_o  (byte_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Priority list starts just after the last served requester; first pending one wins.
  function automatic int unsigned m_pick(input logic [NumReq-1:0] r);
    int unsigned order[$];
    int unsigned pick;
    pick = NumReq;
    for (int k = 1; k <= int'(NumReq); k++) order.push_back((m_last + k) % NumReq);
    foreach (order[j]) begin
      if (pick == NumReq && ((r >> order[j]) & 1) != 0) pick = order[j];
    end
    return pick;
  endfunction

  task automatic check_quiet(input string tag);
    check(tag, {tx_start, |ack, active, timeout_err}, {1'b0, 1'b0, 1'b1, m_err});
  endtask

  // One frame: r requests (busy held for pre_busy cycles first), transmitter stays idle for
  // d cycles after START then busy for f cycles; d >= StartTimeout means it never accepts.
  task automatic do_frame(input logic [NumReq-1:0] r, input int unsigned pre_busy,
                          input int unsigned d, input int unsigned f, input bit keep);
    int unsigned w;
    req     = r;
    tx_busy = (pre_busy != 0);
    for (int unsigned i = 0; i < pre_busy; i++) begin
      step();
      check("busy_hold", {tx_start, active}, 2'b00);
    end
    tx_busy = 1'b0;
    w = m_pick(r);
    if (w == NumReq) begin
      step();
      step();
      check("no_req", {tx_start, |ack, active}, 3'b000);
      return;
    end
    step();
    check("start", tx_start, 1);
    check("ack", ack, 32'(1) << w);
    check("data", tx_data, req_data[8*w +: 8]);
    check("grant", grant_id, w);
    check("active", active, 1);
    m_last = w;
    if (!keep) begin
      if ($urandom_range(1, 0) != 0) req = req & ~(NumReq'(1) << w);
      req_data[8*w +: 8] = 8'($urandom);
    end
    if (d >= StartTimeout) begin
      for (int unsigned i = 1; i < StartTimeout; i++) begin
        step();
        check_quiet("wd_wait");
      end
      step();
      m_err = 1'b1;
      check("timeout_err", timeout_err, m_err);
      check("timeout_idle", active, 0);
      check("timeout_count", byte_count, m_count);
    end else begin
      for (int unsigned i = 0; i < d; i++) begin
        step();
        check_quiet("accept_wait");
      end
      tx_busy = 1'b1;
      for (int unsigned i = 0; i < f; i++) begin
        step();
        check_quiet("frame");
      end
      tx_busy = 1'b0;
      step();
      m_count = m_count + 16'd1;
      check("done_idle", active, 0);
      check("count", byte_count, m_count);
      check("err_keep", timeout_err, m_err);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_start"}, tx_start, 0);
    check({tag, "_data"}, tx_data, 0);
    check({tag, "_grant"}, grant_id, 0);
    check({tag, "_active"}, active, 0);
    check({tag, "_err"}, timeout_err, 0);
    check({tag, "_count"}, byte_count, 0);
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    m_last   = NumReq - 1;
    m_count  = '0;
    m_err    = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    reset = 1'b0;

    // Single byte from requester 0, 10-cycle frame.
    req_data[7:0] = 8'h5A;
    do_frame(2'b01, 0, 1, 10, 1'b1);

    // Both requesters held high: grants must alternate.
    req_data = {8'hB2, 8'hA1};
    for (int i = 0; i < 4; i++) do_frame(2'b11, 0, $urandom_range(StartTimeout - 1, 0), 3, 1'b1);
    check("four_frames", byte_count, 16'd5);

    // Transmitter never accepts, then the next request is still served.
    do_frame(2'b01, 0, StartTimeout, 0, 1'b1);
    do_frame(2'b10, 0, 1, 2, 1'b1);
    // Busy rising on the very last allowed cycle is still an accept.
    do_frame(2'b01, 0, StartTimeout - 1, 3, 1'b1);

    // Transmitter busy while idle blocks the grant.
    do_frame(2'b01, 3, 1, 2, 1'b1);

    // Reset while a byte is in WAIT_DONE after serving requester 0.
    req = 2'b01;
    step();
    check("rst_pre_grant", {tx_start, 1'(grant_id)}, 2'b10);
    m_last  = 0;
    tx_busy = 1'b1;
    step();
    step();
    check("rst_pre_active", active, 1);
    reset = 1'b1;
    req   = 2'b11;
    step();
    check_reset_outputs("midrst");
    reset   = 1'b0;
    tx_busy = 1'b0;
    m_last  = NumReq - 1;
    m_count = '0;
    m_err   = 1'b0;
    do_frame(2'b11, 0, 1, 2, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int unsigned d;
      for (int i = 0; i < int'(NumReq); i++) req_data[8*i +: 8] = 8'($urandom);
      d = ($urandom_range(7, 0) == 0) ? StartTimeout : $urandom_range(StartTimeout - 1, 0);
      do_frame(NumReq'($urandom), ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0,
               d, $urandom_range(8, 2), 1'($urandom));
    end

    // Counter wrap: preload 0xFFFF while idle, then complete one byte.
    req = '0;
    force dut.count_q = 16'hFFFF;
    step();
    release dut.count_q;
    m_count = 16'hFFFF;
    check("preload", byte_count, m_count);
    do_frame(2'b01, 0, 1, 2, 1'b1);
    check("wrap", byte_count, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
